// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the APB timer.
//   - register byte addresses (ADDR_TDR .. ADDR_TIER)
//   - TCR / TSR bit positions
//   - prescaler clock-select encoding and its compare mask
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h04;
  localparam logic [7:0] ADDR_TSR  = 8'h08;
  localparam logic [7:0] ADDR_TCMP = 8'h0C;
  localparam logic [7:0] ADDR_TCNT = 8'h10;
  localparam logic [7:0] ADDR_TIER = 8'h14;

  localparam int TCR_LOAD    = 7;
  localparam int TCR_ONESHOT = 6;
  localparam int TCR_DIR     = 5;
  localparam int TCR_EN      = 4;
  localparam int TCR_ARLD    = 3;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;
  localparam int TSR_CMP = 2;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  // Low prescaler bits that must all be 1 for a tick at the given division.
  function automatic logic [3:0] cks_mask(input cks_e cks);
    case (cks)
      CKS_DIV2:  return 4'b0001;
      CKS_DIV4:  return 4'b0011;
      CKS_DIV8:  return 4'b0111;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/apb_timer_param_if.sv
// apb_timer_param_if: APB signal bundle for the timer.
//   master: drives psel, penable, pwrite, paddr, pwdata
//   slave : drives prdata, pready, pslverr
interface apb_timer_param_if #(
  parameter int DATA_W = 32
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [7:0]        paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running 4-bit prescaler producing a 1-cycle tick.
//   pclk, presetn : clock, async active-low reset
//   en            : advance the prescaler
//   hold          : force the prescaler to 0 (load in progress)
//   cks           : division select, tick every 2^(cks+1) cycles
//   tick          : single-cycle count enable for the main counter
// The tick fires when the low cks+1 bits are all ones, i.e. on the carry out
// of bit cks. Changing cks therefore keeps the current phase.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic pclk,
  input  logic presetn,
  input  logic en,
  input  logic hold,
  input  cks_e cks,
  output logic tick
);

  logic [3:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    if (hold) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_q + 4'd1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = en & ~hold & ((presc_q | ~cks_mask(cks)) == 4'hF);

endmodule

// File: rtl/apb_timer_param.sv
// apb_timer_param: parametrised APB timer/counter with compare, auto-reload
// and maskable interrupt.
//   pclk, presetn : clock, async active-low reset
//   apb           : APB slave port (zero wait states, pslverr on unmapped)
//   irq           : level interrupt, OR of (TSR & TIER)
// Registers: TDR 0x00, TCR 0x04, TSR 0x08 (write-0-to-clear), TCMP 0x0C,
// TCNT 0x10 (read-only), TIER 0x14.
// Optional build macro TIMER_ONESHOT_EN: adds TCR bit6 oneshot, which clears
// en on an overflow/underflow so the counter stops at its wrap value.
module apb_timer_param
  import timer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic                pclk,
  input  logic                presetn,
  apb_timer_param_if.slave    apb,
  output logic                irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] tdr_q, tdr_d;
  logic [CNT_W-1:0] tcmp_q, tcmp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       tier_q, tier_d;
  logic [2:0]       tsr_q, tsr_d;
  logic             load_q, load_d;
  logic             dir_q, dir_d;
  logic             en_q, en_d;
  logic             arld_q, arld_d;
  cks_e             cks_q, cks_d;
  logic             oneshot;

  logic acc, wr;
  logic sel_tdr, sel_tcr, sel_tsr, sel_tcmp, sel_tcnt, sel_tier, mapped;
  logic tick;
  logic ovf_set, udf_set, cmp_set;
  logic [DATA_W-1:0] rdata;
  logic unused_pwdata;

  assign acc = apb.psel & apb.penable;
  assign wr  = acc & apb.pwrite;

  always_comb begin
    sel_tdr  = (apb.paddr == ADDR_TDR);
    sel_tcr  = (apb.paddr == ADDR_TCR);
    sel_tsr  = (apb.paddr == ADDR_TSR);
    sel_tcmp = (apb.paddr == ADDR_TCMP);
    sel_tcnt = (apb.paddr == ADDR_TCNT);
    sel_tier = (apb.paddr == ADDR_TIER);
    mapped   = sel_tdr | sel_tcr | sel_tsr | sel_tcmp | sel_tcnt | sel_tier;
  end

  // Upper write-data bits have no register behind them.
  assign unused_pwdata = ^apb.pwdata;

  timer_prescaler u_presc (
    .pclk    (pclk),
    .presetn (presetn),
    .en      (en_q),
    .hold    (load_q),
    .cks     (cks_q),
    .tick    (tick)
  );

  // Counter: load dominates; otherwise step on tick with wrap handling.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    cmp_set = 1'b0;
    if (load_q) begin
      cnt_d = tdr_q;
    end else if (tick) begin
      if (!dir_q) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = arld_q ? tdr_q : '0;
          ovf_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d   = arld_q ? tdr_q : CNT_MAX;
          udf_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      cmp_set = (cnt_d == tcmp_q);
    end
  end

  always_comb begin
    tdr_d  = (wr & sel_tdr)  ? apb.pwdata[CNT_W-1:0] : tdr_q;
    tcmp_d = (wr & sel_tcmp) ? apb.pwdata[CNT_W-1:0] : tcmp_q;
    tier_d = (wr & sel_tier) ? apb.pwdata[2:0]       : tier_q;
  end

  always_comb begin
    load_d = load_q;
    dir_d  = dir_q;
    en_d   = en_q;
    arld_d = arld_q;
    cks_d  = cks_q;
    if (wr & sel_tcr) begin
      load_d = apb.pwdata[TCR_LOAD];
      dir_d  = apb.pwdata[TCR_DIR];
      en_d   = apb.pwdata[TCR_EN];
      arld_d = apb.pwdata[TCR_ARLD];
      cks_d  = cks_e'(apb.pwdata[1:0]);
    end
    // Oneshot stop beats a simultaneous software write of en.
    if (oneshot & (ovf_set | udf_set)) begin
      en_d = 1'b0;
    end
  end

  // Hardware set beats a software clear in the same cycle.
  always_comb begin
    tsr_d = tsr_q;
    if (wr & sel_tsr) begin
      tsr_d = tsr_q & apb.pwdata[2:0];
    end
    tsr_d[TSR_OVF] = tsr_d[TSR_OVF] | ovf_set;
    tsr_d[TSR_UDF] = tsr_d[TSR_UDF] | udf_set;
    tsr_d[TSR_CMP] = tsr_d[TSR_CMP] | cmp_set;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr_q  <= '0;
      tcmp_q <= '0;
      cnt_q  <= '0;
      tier_q <= '0;
      tsr_q  <= '0;
      load_q <= 1'b0;
      dir_q  <= 1'b0;
      en_q   <= 1'b0;
      arld_q <= 1'b0;
      cks_q  <= CKS_DIV2;
    end else begin
      tdr_q  <= tdr_d;
      tcmp_q <= tcmp_d;
      cnt_q  <= cnt_d;
      tier_q <= tier_d;
      tsr_q  <= tsr_d;
      load_q <= load_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      arld_q <= arld_d;
      cks_q  <= cks_d;
    end
  end

`ifdef TIMER_ONESHOT_EN
  logic oneshot_q, oneshot_d;

  always_comb begin
    oneshot_d = (wr & sel_tcr) ? apb.pwdata[TCR_ONESHOT] : oneshot_q;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      oneshot_q <= 1'b0;
    end else begin
      oneshot_q <= oneshot_d;
    end
  end

  assign oneshot = oneshot_q;
`else
  assign oneshot = 1'b0;
`endif

  // Read data is combinational so it is valid within the access cycle.
  always_comb begin
    rdata = '0;
    if (apb.psel & ~apb.pwrite) begin
      if (sel_tdr)  rdata = DATA_W'(tdr_q);
      if (sel_tcr)  rdata = DATA_W'({load_q, oneshot, dir_q, en_q, arld_q, 1'b0, 2'(cks_q)});
      if (sel_tsr)  rdata = DATA_W'(tsr_q);
      if (sel_tcmp) rdata = DATA_W'(tcmp_q);
      if (sel_tcnt) rdata = DATA_W'(cnt_q);
      if (sel_tier) rdata = DATA_W'(tier_q);
    end
  end

  assign apb.prdata  = rdata;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = acc & ~mapped;
  assign irq         = |(tsr_q & tier_q);

endmodule

// File: tb/tb_apb_timer_param.sv
module tb_apb_timer_param;
  import timer_pkg::*;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic irq;
  int   checks = 0;
  int   failures = 0;

  apb_timer_param_if #(.DATA_W(32)) bus ();

  apb_timer_param #(.CNT_W(16), .DATA_W(32)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (bus),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  task automatic idle_bus();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 8'h00;
    bus.pwdata  = 32'h0;
  endtask

  task automatic do_reset();
    idle_bus();
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Called at posedge+1; returns at commit edge + 1.
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = a;
    bus.pwdata  = d;
    @(posedge pclk);
    #1 bus.penable = 1'b1;
    @(posedge pclk);
    #1 idle_bus();
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b0;
    bus.penable = 1'b0;
    bus.paddr   = a;
    @(posedge pclk);
    #1 bus.penable = 1'b1;
    #1;
    d = bus.prdata;
    e = bus.pslverr;
    @(posedge pclk);
    #1 idle_bus();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        err;
    logic [7:0]  addrs [6];
    addrs = '{ADDR_TDR, ADDR_TCR, ADDR_TSR, ADDR_TCMP, ADDR_TCNT, ADDR_TIER};
    do_reset();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++;
    if (bus.pready !== 1'b1) begin failures++; $display("FAIL reset_pready got=%b exp=1", bus.pready); end
    for (int i = 0; i < 6; i++) begin
      apb_read(addrs[i], rd, err);
      checks++;
      if (rd !== 32'h0 || err !== 1'b0) begin
        failures++;
        $display("FAIL reset_reg addr=%h got=%h err=%b exp=0 err=0", addrs[i], rd, err);
      end
    end
  endtask

  task automatic test_up_count();
    logic [31:0] rd;
    logic        err;
    do_reset();
    apb_write(ADDR_TCMP, 32'h1234);
    apb_write(ADDR_TIER, 32'h1);
    apb_write(ADDR_TDR,  32'hFFF0);
    apb_write(ADDR_TCR,  32'h80);
    apb_write(ADDR_TCR,  32'h10);
    wait_edges(31);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL up_irq_before_ovf got=%b exp=0", irq); end
    wait_edges(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL up_ovf_at_32 got=%b exp=1", irq); end
    apb_read(ADDR_TSR, rd, err);
    checks++;
    if (rd !== 32'h01) begin failures++; $display("FAIL up_tsr got=%h exp=01", rd); end
    apb_write(ADDR_TSR, 32'h0);
    apb_read(ADDR_TSR, rd, err);
    checks++;
    if (rd !== 32'h00) begin failures++; $display("FAIL up_tsr_clear got=%h exp=00", rd); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL up_irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_pause_resume();
    logic [31:0] rd;
    logic        err;
    do_reset();
    apb_write(ADDR_TCMP, 32'h1234);
    apb_write(ADDR_TIER, 32'h1);
    apb_write(ADDR_TDR,  32'hFFF0);
    apb_write(ADDR_TCR,  32'h80);
    apb_write(ADDR_TCR,  32'h10);
    wait_edges(8);
    apb_write(ADDR_TCR, 32'h00);
    apb_read(ADDR_TCNT, rd, err);
    checks++;
    if (rd !== 32'hFFF5) begin failures++; $display("FAIL pause_tcnt_start got=%h exp=fff5", rd); end
    wait_edges(50);
    apb_read(ADDR_TCNT, rd, err);
    checks++;
    if (rd !== 32'hFFF5) begin failures++; $display("FAIL pause_tcnt_held got=%h exp=fff5", rd); end
    apb_write(ADDR_TCR, 32'h10);
    wait_edges(21);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL resume_irq_early got=%b exp=0", irq); end
    wait_edges(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL resume_ovf_at_22 got=%b exp=1", irq); end
  endtask

  task automatic test_down_reload();
    logic [31:0] rd;
    logic        err;
    do_reset();
    apb_write(ADDR_TCMP, 32'h00FF);
    apb_write(ADDR_TIER, 32'h2);
    apb_write(ADDR_TDR,  32'h0003);
    apb_write(ADDR_TCR,  32'h80);
    apb_write(ADDR_TCR,  32'h38);
    wait_edges(7);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL down_irq_early got=%b exp=0", irq); end
    wait_edges(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL down_udf_tick4 got=%b exp=1", irq); end
    apb_read(ADDR_TCNT, rd, err);
    checks++;
    if (rd !== 32'h0003) begin failures++; $display("FAIL down_reload_cnt got=%h exp=0003", rd); end
    apb_read(ADDR_TSR, rd, err);
    checks++;
    if (rd !== 32'h02) begin failures++; $display("FAIL down_tsr got=%h exp=02", rd); end
  endtask

  task automatic test_compare_irq();
    logic [31:0] rd;
    logic        err;
    do_reset();
    apb_write(ADDR_TCMP, 32'h0005);
    apb_write(ADDR_TIER, 32'h4);
    apb_write(ADDR_TDR,  32'h0000);
    apb_write(ADDR_TCR,  32'h80);
    apb_write(ADDR_TCR,  32'h11);
    wait_edges(19);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL cmp_irq_early got=%b exp=0", irq); end
    wait_edges(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL cmp_irq_at_20 got=%b exp=1", irq); end
    apb_read(ADDR_TSR, rd, err);
    checks++;
    if (rd !== 32'h04) begin failures++; $display("FAIL cmp_tsr got=%h exp=04", rd); end
    apb_write(ADDR_TSR, 32'h0);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL cmp_irq_drop got=%b exp=0", irq); end
  endtask

  task automatic test_race();
    logic [31:0] rd;
    logic        err;
    do_reset();
    apb_write(ADDR_TCMP, 32'h1234);
    apb_write(ADDR_TDR,  32'hFFF0);
    apb_write(ADDR_TCR,  32'h80);
    apb_write(ADDR_TCR,  32'h10);
    wait_edges(30);
    apb_write(ADDR_TSR, 32'h0);
    apb_read(ADDR_TSR, rd, err);
    checks++;
    if (rd !== 32'h01) begin failures++; $display("FAIL race_ovf_wins got=%h exp=01", rd); end
    apb_write(ADDR_TSR, 32'h0);
    apb_read(ADDR_TSR, rd, err);
    checks++;
    if (rd !== 32'h00) begin failures++; $display("FAIL race_later_clear got=%h exp=00", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic        err;
    do_reset();
    apb_write(ADDR_TDR, 32'h00AA);
    apb_write(8'h1C, 32'hFFFF_FFFF);
    apb_write(ADDR_TCNT, 32'h5555);
    apb_read(8'h1C, rd, err);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL unmapped_pslverr got=%b exp=1", err); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL unmapped_prdata got=%h exp=0", rd); end
    apb_read(ADDR_TDR, rd, err);
    checks++;
    if (rd !== 32'h00AA || err !== 1'b0) begin
      failures++;
      $display("FAIL unmapped_no_effect got=%h err=%b exp=00aa err=0", rd, err);
    end
    apb_read(ADDR_TCNT, rd, err);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL tcnt_write_ignored got=%h err=%b exp=0 err=0", rd, err);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] rd;
    logic        err;
    do_reset();
    apb_write(ADDR_TIER, 32'h7);
    apb_write(ADDR_TDR,  32'hFFFE);
    apb_write(ADDR_TCR,  32'h80);
    apb_write(ADDR_TCR,  32'h10);
    wait_edges(2);
    apb_write(ADDR_TCR,  32'h30);
    wait_edges(2);
    apb_read(ADDR_TSR, rd, err);
    checks++;
    if (rd !== 32'h07) begin failures++; $display("FAIL midrst_tsr_pre got=%h exp=07", rd); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL midrst_irq_pre got=%b exp=1", irq); end
    presetn = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL midrst_irq_now got=%b exp=0", irq); end
    checks++;
    if (bus.prdata !== 32'h0) begin failures++; $display("FAIL midrst_prdata got=%h exp=0", bus.prdata); end
    repeat (3) @(posedge pclk);
    #3 presetn = 1'b1;
    @(posedge pclk);
    #1;
    apb_read(ADDR_TCNT, rd, err);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL midrst_tcnt got=%h exp=0", rd); end
    apb_read(ADDR_TSR, rd, err);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL midrst_tsr got=%h exp=0", rd); end
    apb_read(ADDR_TCR, rd, err);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL midrst_tcr got=%h exp=0", rd); end
    apb_read(ADDR_TDR, rd, err);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL midrst_tdr got=%h exp=0", rd); end
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_up_count();
    test_pause_resume();
    test_down_reload();
    test_compare_irq();
    test_race();
    test_unmapped();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
